wormhole_output_arbiter: RTL and testbench

- Per-output-port allocator for the 5-port mesh wormhole router.
- Consumes the head-of-queue status of the five input buffers and downstream readiness.
- Drives the one-hot select of the 5:1 output flit mux, plus the per-buffer pop strobes.
- Holds a grant for the whole packet (head to tail) and rotates priority round-robin between packets.

---
 rtl/noc_pkg.sv | 33 +++
 rtl/rr_pick5.sv | 32 +++
 rtl/wormhole_output_arbiter.sv | 112 +++++++++++
 tb/tb_wormhole_output_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: port count, flit type encoding, index helpers.
// No logic of its own; functions are purely combinational.
// No flow control here; consumers own all handshaking.
package noc_pkg;

   localparam int NUM_PORTS = 5;

   // Flit type lives in the top two bits of every flit.
   localparam logic [1:0] FT_BODY = 2'b00;
   localparam logic [1:0] FT_HEAD = 2'b01;
   localparam logic [1:0] FT_TAIL = 2'b10;
   localparam logic [1:0] FT_HT   = 2'b11;

   typedef logic [1:0] flit_type_t;

   // A head+tail flit both opens and closes a packet.
   function automatic logic is_head(input flit_type_t ft);
      return (ft == FT_HEAD) || (ft == FT_HT);
   endfunction

   function automatic logic is_tail(input flit_type_t ft);
      return (ft == FT_TAIL) || (ft == FT_HT);
   endfunction

   // Port indices wrap modulo 5; operands are always 0..4 so one subtraction suffices.
   function automatic logic [2:0] mod5_add(input logic [2:0] a, input logic [2:0] b);
      logic [3:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= 4'd5) s = s - 4'd5;
      return s[2:0];
   endfunction

endpackage

// File: rtl/rr_pick5.sv
// Round-robin picker over five requesters, starting the scan at rr_ptr.
// Purely combinational, zero latency.
// No backpressure; grant_vld simply reports whether anything was eligible.
module rr_pick5
   import noc_pkg::*;
(
   input  logic [NUM_PORTS-1:0] eligible,
   input  logic [2:0]           rr_ptr,
   output logic [NUM_PORTS-1:0] grant,
   output logic [2:0]           grant_idx,
   output logic                 grant_vld
);

   logic [2:0] idx;

   // Scan rr_ptr, rr_ptr+1, ... (mod 5) and take the first eligible input.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      idx       = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = mod5_add(rr_ptr, 3'(k));
         if (!grant_vld && eligible[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            grant_vld  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wormhole_output_arbiter.sv
// Per-output wormhole allocator: locks the output to one input from head to tail, round-robin between packets.
// One arbitration cycle in IDLE; head flit moves at the earliest the following cycle.
// Bubbles (req drop or out_ready low) stall the transfer but never release the lock.
module wormhole_output_arbiter
   import noc_pkg::*;
#(
   parameter int FLIT_W  = 8,
   parameter int RR_INIT = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_PORTS-1:0] req,
   input  logic [FLIT_W-1:0]    in_flit0,
   input  logic [FLIT_W-1:0]    in_flit1,
   input  logic [FLIT_W-1:0]    in_flit2,
   input  logic [FLIT_W-1:0]    in_flit3,
   input  logic [FLIT_W-1:0]    in_flit4,
   input  logic                 out_ready,
   output logic [NUM_PORTS-1:0] select,
   output logic [NUM_PORTS-1:0] pop,
   output logic                 locked,
   output logic [2:0]           owner
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t               state_q, state_d;
   logic [2:0]           owner_q, owner_d;
   logic [NUM_PORTS-1:0] owner_oh_q, owner_oh_d;
   logic [2:0]           rr_ptr_q, rr_ptr_d;

   flit_type_t           ft [NUM_PORTS];
   logic [NUM_PORTS-1:0] eligible;
   logic [NUM_PORTS-1:0] pick_grant;
   logic [2:0]           pick_idx;
   logic                 pick_vld;

   // Only the type bits steer the arbiter; the payload passes through the external mux.
   logic unused_payload;
   assign unused_payload = ^{in_flit0[FLIT_W-3:0], in_flit1[FLIT_W-3:0], in_flit2[FLIT_W-3:0],
                             in_flit3[FLIT_W-3:0], in_flit4[FLIT_W-3:0]};

   assign ft[0] = in_flit0[FLIT_W-1:FLIT_W-2];
   assign ft[1] = in_flit1[FLIT_W-1:FLIT_W-2];
   assign ft[2] = in_flit2[FLIT_W-1:FLIT_W-2];
   assign ft[3] = in_flit3[FLIT_W-1:FLIT_W-2];
   assign ft[4] = in_flit4[FLIT_W-1:FLIT_W-2];

   // An input may only win with a head flit; stray body/tail flits are ignored.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         eligible[i] = req[i] && is_head(ft[i]);
      end
   end

   rr_pick5 u_pick (
      .eligible  (eligible),
      .rr_ptr    (rr_ptr_q),
      .grant     (pick_grant),
      .grant_idx (pick_idx),
      .grant_vld (pick_vld)
   );

   // Next-state and select generation; select depends only on registered owner, req and out_ready.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      owner_oh_d = owner_oh_q;
      rr_ptr_d   = rr_ptr_q;
      select     = '0;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               owner_d    = pick_idx;
               owner_oh_d = pick_grant;
               state_d    = LOCKED;
            end
         end
         LOCKED: begin
            select = owner_oh_q & req & {NUM_PORTS{out_ready}};
            if ((|select) && is_tail(ft[owner_q])) begin
               state_d  = IDLE;
               rr_ptr_d = mod5_add(owner_q, 3'd1);
            end
         end
         default: state_d = IDLE;
      endcase
      // Reset mid-packet must not pop anything in that cycle.
      if (!rst_n) select = '0;
   end

   // State, owner and round-robin pointer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         owner_oh_q <= 5'b00001;
         rr_ptr_q   <= 3'(RR_INIT);
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         owner_oh_q <= owner_oh_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign pop    = select;
   assign locked = (state_q == LOCKED);
   assign owner  = owner_q;

endmodule

// File: tb/tb_wormhole_output_arbiter.sv
// Directed bench for wormhole_output_arbiter with input-buffer model and transfer scoreboard.
// Each step drives one cycle and checks select/locked; every transfer is matched against queued expectations.
// out_ready is driven directly to exercise stalls.
module tb_wormhole_output_arbiter;

   logic       clk;
   logic       rst_n;
   logic [4:0] req;
   logic [7:0] flit [5];
   logic       out_ready;
   logic [4:0] select;
   logic [4:0] pop;
   logic       locked;
   logic [2:0] owner;

   int total = 0;
   int bad   = 0;

   logic [7:0]  srcq [5][$];
   logic [10:0] sbq [$];

   wormhole_output_arbiter #(.FLIT_W(8), .RR_INIT(0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .in_flit0  (flit[0]),
      .in_flit1  (flit[1]),
      .in_flit2  (flit[2]),
      .in_flit3  (flit[3]),
      .in_flit4  (flit[4]),
      .out_ready (out_ready),
      .select    (select),
      .pop       (pop),
      .locked    (locked),
      .owner     (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input int idx, input logic [7:0] f);
      sbq.push_back({3'(idx), f});
   endtask

   // One cycle: present buffer heads, check outputs, score any transfer, advance the buffer model.
   task automatic cyc(input logic [4:0] exp_sel, input logic exp_lock, input string tag);
      int idx;
      logic [10:0] e;
      for (int i = 0; i < 5; i++) begin
         req[i]  = (srcq[i].size() != 0);
         flit[i] = (srcq[i].size() != 0) ? srcq[i][0] : 8'h00;
      end
      #1;
      chk({tag, "/sel"}, 32'(select), 32'(exp_sel));
      chk({tag, "/pop"}, 32'(pop), 32'(exp_sel));
      chk({tag, "/locked"}, 32'(locked), 32'(exp_lock));
      if (select !== 5'b0) begin
         idx = -1;
         for (int i = 0; i < 5; i++) if (select[i] === 1'b1 && idx < 0) idx = i;
         if (idx >= 0) begin
            chk({tag, "/sb_nonempty"}, 32'(sbq.size() > 0), 32'd1);
            if (sbq.size() > 0) begin
               e = sbq.pop_front();
               chk({tag, "/xfer"}, 32'({3'(idx), flit[idx]}), 32'(e));
            end
            if (srcq[idx].size() != 0) void'(srcq[idx].pop_front());
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      req       = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) flit[i] = 8'h00;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      cyc(5'b00000, 1'b0, "rst");
      chk("rst/rr", 32'(dut.rr_ptr_q), 32'd0);
      chk("rst/owner", 32'(owner), 32'd0);
      rst_n = 1'b1;

      // Basic three-flit packet on input 0
      srcq[0] = '{8'h41, 8'h02, 8'h83};
      sb_push(0, 8'h41); sb_push(0, 8'h02); sb_push(0, 8'h83);
      cyc(5'b00000, 1'b0, "p0_arb");
      cyc(5'b00001, 1'b1, "p0_h");
      cyc(5'b00001, 1'b1, "p0_b");
      cyc(5'b00001, 1'b1, "p0_t");
      cyc(5'b00000, 1'b0, "p0_done");
      chk("p0/rr", 32'(dut.rr_ptr_q), 32'd1);

      // Contention: fresh reset so rr_ptr=0, all five inputs with two-flit packets
      rst_n = 1'b0;
      cyc(5'b00000, 1'b0, "rst2");
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         srcq[i] = '{8'h40 | 8'(i), 8'h80 | 8'(i)};
      end
      for (int i = 0; i < 5; i++) begin
         sb_push(i, 8'h40 | 8'(i));
         sb_push(i, 8'h80 | 8'(i));
      end
      for (int i = 0; i < 5; i++) begin
         cyc(5'b00000, 1'b0, "cont_idle");
         cyc(5'(1 << i), 1'b1, "cont_h");
         cyc(5'(1 << i), 1'b1, "cont_t");
      end
      chk("cont/rr_wrap", 32'(dut.rr_ptr_q), 32'd0);

      // Backpressure on input 2, input 3 joins mid-packet
      srcq[2] = '{8'h42, 8'h02, 8'h82};
      sb_push(2, 8'h42); sb_push(2, 8'h02); sb_push(2, 8'h82);
      sb_push(3, 8'h43); sb_push(3, 8'h83);
      cyc(5'b00000, 1'b0, "bp_arb");
      out_ready = 1'b1;
      cyc(5'b00100, 1'b1, "bp_h");
      out_ready = 1'b0;
      srcq[3] = '{8'h43, 8'h83};
      cyc(5'b00000, 1'b1, "bp_stall1");
      chk("bp/owner", 32'(owner), 32'd2);
      cyc(5'b00000, 1'b1, "bp_stall2");
      out_ready = 1'b1;
      cyc(5'b00100, 1'b1, "bp_b");
      cyc(5'b00100, 1'b1, "bp_t");
      cyc(5'b00000, 1'b0, "bp_gap");
      cyc(5'b01000, 1'b1, "bp_in3_h");
      cyc(5'b01000, 1'b1, "bp_in3_t");
      chk("bp/rr", 32'(dut.rr_ptr_q), 32'd4);

      // Single-flit packet on input 3
      srcq[3] = '{8'hC7};
      sb_push(3, 8'hC7);
      cyc(5'b00000, 1'b0, "ht_arb");
      cyc(5'b01000, 1'b1, "ht_x");
      cyc(5'b00000, 1'b0, "ht_idle");
      chk("ht/rr", 32'(dut.rr_ptr_q), 32'd4);

      // Body flit at head of input 1 must never be granted
      srcq[1] = '{8'h05};
      for (int i = 0; i < 10; i++) cyc(5'b00000, 1'b0, "filt");
      srcq[1].delete();
      chk("filt/rr", 32'(dut.rr_ptr_q), 32'd4);

      // Reset after the second body flit of a four-flit packet on input 0
      srcq[0] = '{8'h40, 8'h01, 8'h02, 8'h81};
      sb_push(0, 8'h40); sb_push(0, 8'h01); sb_push(0, 8'h02);
      cyc(5'b00000, 1'b0, "mr_arb");
      cyc(5'b00001, 1'b1, "mr_h");
      cyc(5'b00001, 1'b1, "mr_b1");
      cyc(5'b00001, 1'b1, "mr_b2");
      rst_n = 1'b0;
      cyc(5'b00000, 1'b1, "mr_rst");
      chk("mr/locked_after", 32'(locked), 32'd0);
      chk("mr/rr_after", 32'(dut.rr_ptr_q), 32'd0);
      rst_n = 1'b1;
      srcq[0] = '{8'h40, 8'h80};
      sb_push(0, 8'h40); sb_push(0, 8'h80);
      cyc(5'b00000, 1'b0, "mr_rearb");
      cyc(5'b00001, 1'b1, "mr_h2");
      cyc(5'b00001, 1'b1, "mr_t2");
      cyc(5'b00000, 1'b0, "mr_done");
      chk("mr/rr_final", 32'(dut.rr_ptr_q), 32'd1);

      chk("sb/drained", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
